// File: rtl/effect_chorus.sv
// effect_chorus -- modulated-delay chorus stage.
//
// The recent input history is kept in an on-chip circular buffer. A triangle
// LFO sweeps a read tap between BASE_DLY and BASE_DLY+MOD_DEPTH samples behind
// the write pointer. The output is the 50/50 mix of the dry sample and the
// tapped (wet) sample. Samples arrive as one-cycle i_valid pulses and leave as
// one-cycle o_valid pulses.
//
// Optional feature macro: CHORUS_INTERP_EN
//   defined   : linear interpolation between two adjacent taps using the LFO
//               fractional bits (extra read state, latency 4)
//   undefined : nearest-lower tap, fraction truncated (latency 3)
//
// Ports:
//   i_clk     audio bit clock, single clock domain
//   i_rst_n   asynchronous active-low reset
//   i_valid   one-cycle pulse marking a new input sample
//   i_enable  1 = chorus mix, 0 = dry bypass with identical latency
//   i_level   LFO rate, step = i_level+1 sixteenths of a sample per sample
//   i_data    signed 16-bit input sample
//   o_data    signed 16-bit output sample, held between valids
//   o_valid   one-cycle pulse when o_data is updated
`timescale 1ns/1ps
module effect_chorus #(
  parameter int ADDR_W    = 10,
  parameter int BASE_DLY  = 256,
  parameter int MOD_DEPTH = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [2:0]         i_level,
  input  logic signed [15:0] i_data,
  output logic signed [15:0] o_data,
  output logic               o_valid
);

  localparam int DATA_W   = 16;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int LFO_MAX  = MOD_DEPTH * 16;
  localparam int LFO_W    = $clog2(LFO_MAX + 1);
  localparam int FILL_MAX = BASE_DLY + MOD_DEPTH + 2;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);

  localparam logic [LFO_W:0]    LFO_TOP  = (LFO_W + 1)'(LFO_MAX);
  localparam logic [FILL_W-1:0] FILL_TOP = FILL_W'(FILL_MAX);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_DLY);

`ifdef CHORUS_INTERP_EN
  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_MIX, S_OUT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RD0, S_MIX, S_OUT} state_t;
`endif
  typedef enum logic {DIR_UP, DIR_DN} dir_t;

  state_t                   state, state_nxt;
  logic                     accept;
  logic [ADDR_W-1:0]        wr_ptr, addr_a, addr_p0, rd_addr;
  logic [LFO_W-1:0]         lfo_pos, lfo_pos_nxt;
  logic [LFO_W:0]           up_sum;
  dir_t                     lfo_dir, lfo_dir_nxt;
  logic [FILL_W-1:0]        fill_cnt;
  logic                     en_p0;
  logic [3:0]               step_p0;
  logic signed [DATA_W-1:0] mem [DEPTH];
  logic signed [DATA_W-1:0] rd_q, dry_p0, wet, mix_p2;
`ifdef CHORUS_INTERP_EN
  logic signed [DATA_W-1:0] tap_a_p1;
`endif

  // Halved sum of two samples; the 17-bit sum shifted right by one always fits.
  function automatic logic signed [DATA_W-1:0] mix_half(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W:0] s;
    s = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
    return s[DATA_W:1];
  endfunction

`ifdef CHORUS_INTERP_EN
  // a + ((b - a) * frac) >>> 4; the result lies between a and b, so it fits.
  function automatic logic signed [DATA_W-1:0] interp(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [3:0]               frac
  );
    logic signed [DATA_W:0]   diff;
    logic signed [21:0]       prod;
    logic signed [DATA_W+1:0] acc;
    diff = $signed({b[DATA_W-1], b}) - $signed({a[DATA_W-1], a});
    prod = diff * $signed({1'b0, frac});
    acc  = $signed({{2{a[DATA_W-1]}}, a}) + (DATA_W + 2)'(prod >>> 4);
    return acc[DATA_W-1:0];
  endfunction
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: if (i_valid) begin
        accept    = 1'b1;
        state_nxt = S_RD0;
      end
`ifdef CHORUS_INTERP_EN
      S_RD0:  state_nxt = S_RD1;
      S_RD1:  state_nxt = S_MIX;
`else
      S_RD0:  state_nxt = S_MIX;
`endif
      S_MIX:  state_nxt = S_OUT;
      S_OUT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tap address: integer part of the LFO added to the fixed base delay.
  assign addr_a = wr_ptr - BASE_A - ADDR_W'(lfo_pos[LFO_W-1:4]);

`ifdef CHORUS_INTERP_EN
  assign rd_addr = (state == S_RD1) ? addr_p0 - ADDR_W'(1) : addr_p0;
`else
  assign rd_addr = addr_p0;
`endif

  // Triangle LFO: clamp to the bound when reaching or passing it, then turn.
  always_comb begin
    up_sum      = {1'b0, lfo_pos} + (LFO_W + 1)'(step_p0);
    lfo_pos_nxt = lfo_pos;
    lfo_dir_nxt = lfo_dir;
    if (lfo_dir == DIR_UP) begin
      if (up_sum >= LFO_TOP) begin
        lfo_pos_nxt = LFO_TOP[LFO_W-1:0];
        lfo_dir_nxt = DIR_DN;
      end else begin
        lfo_pos_nxt = up_sum[LFO_W-1:0];
      end
    end else begin
      if (lfo_pos <= LFO_W'(step_p0)) begin
        lfo_pos_nxt = '0;
        lfo_dir_nxt = DIR_UP;
      end else begin
        lfo_pos_nxt = lfo_pos - LFO_W'(step_p0);
      end
    end
  end

  // Wet path stays muted until the history covers the deepest tap.
  always_comb begin
`ifdef CHORUS_INTERP_EN
    wet = interp(tap_a_p1, rd_q, lfo_pos[3:0]);
`else
    wet = rd_q;
`endif
    if (fill_cnt < FILL_TOP) wet = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      lfo_pos  <= '0;
      lfo_dir  <= DIR_UP;
      fill_cnt <= '0;
      en_p0    <= 1'b0;
      step_p0  <= 4'd1;
      o_data   <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      // p0: accept -- sample enable and rate, advance the write pointer
      if (accept) begin
        en_p0   <= i_enable;
        step_p0 <= {1'b0, i_level} + 4'd1;
        wr_ptr  <= wr_ptr + ADDR_W'(1);
      end
      // output stage: publish, then advance LFO and fill counter
      if (state == S_OUT) begin
        o_data   <= en_p0 ? mix_p2 : dry_p0;
        o_valid  <= 1'b1;
        lfo_pos  <= lfo_pos_nxt;
        lfo_dir  <= lfo_dir_nxt;
        if (fill_cnt != FILL_TOP) fill_cnt <= fill_cnt + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    // p0: write history, hold dry sample and tap address
    if (accept) begin
      mem[wr_ptr] <= i_data;
      dry_p0      <= i_data;
      addr_p0     <= addr_a;
    end
    // p1: synchronous buffer read
    rd_q <= mem[rd_addr];
`ifdef CHORUS_INTERP_EN
    if (state == S_RD1) tap_a_p1 <= rd_q;
`endif
    // p2: dry/wet mix
    if (state == S_MIX) mix_p2 <= mix_half(dry_p0, wet);
  end

endmodule

// File: tb/tb_effect_chorus.sv
// tb_effect_chorus -- directed bench for effect_chorus: reset values, bypass
// latency, fill muting, extreme-value mixing, LFO triangle sweep with an
// impulse-train reference, mid-sample reset and busy-window valid rejection.
`timescale 1ns/1ps
module tb_effect_chorus;

`ifdef CHORUS_INTERP_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_valid;
  logic               i_enable;
  logic [2:0]         i_level;
  logic signed [15:0] i_data;
  logic signed [15:0] o_data;
  logic               o_valid;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 i_clk = ~i_clk;

  effect_chorus dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .i_enable(i_enable),
    .i_level (i_level),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_valid (o_valid)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle.
  task automatic send(input logic signed [15:0] d, input logic en,
                      input logic [2:0] lvl, output logic signed [15:0] out,
                      output logic ok);
    i_data   = d;
    i_enable = en;
    i_level  = lvl;
    i_valid  = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    ok  = 1'b0;
    out = '0;
    for (int k = 0; k < 16 && !ok; k++) begin
      @(posedge i_clk); #1;
      if (o_valid) begin
        out = o_data;
        ok  = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  // Triangle position after k samples at step 8 (rate 7), peak 4080.
  function automatic int lfo_model(input int k);
    if (k <= 510)       return 8 * k;
    else if (k <= 1020) return 4080 - 8 * (k - 510);
    else                return 8 * (k - 1020);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] out;
    logic               ok;
    int                 xs [1100];
    int                 xv, expv, p, dl, w, ta, wetv, pulses;
`ifdef CHORUS_INTERP_EN
    int                 tb, fr;
`endif

    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_enable = 1'b0;
    i_level  = 3'd0;
    i_data   = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_o_data", o_data, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_wr_ptr", dut.wr_ptr, 0);
    chk("rst_lfo_pos", dut.lfo_pos, 0);
    chk("rst_fill_cnt", dut.fill_cnt, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Bypass latency and single-cycle pulse
    i_data   = 16'sh1234;
    i_enable = 1'b0;
    i_valid  = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge i_clk); #1;
      chk("byp_valid", o_valid, (k == LAT));
      chk("byp_data", o_data, (k >= LAT) ? 32'sh1234 : 32'sd0);
    end

    // Fill mute: first 513 outputs carry only half the dry sample
    do_reset();
    for (int n = 1; n <= 600; n++) begin
      send(16'sd1000, 1'b1, 3'd3, out, ok);
      chk("fill_valid", ok, 1);
      chk("fill_data", out, (n <= 513) ? 500 : 1000);
    end

    // Extreme values mix without overflow
    for (int n = 1; n <= 520; n++) begin
      send(16'sd32767, 1'b1, 3'd3, out, ok);
      chk("max_valid", ok, 1);
      if (n >= 515) chk("max_data", out, 32767);
    end
    for (int n = 1; n <= 520; n++) begin
      send(-16'sd32768, 1'b1, 3'd3, out, ok);
      chk("min_valid", ok, 1);
      if (n >= 515) chk("min_data", out, -32768);
    end

    // LFO sweep at rate 7 with an impulse every 5th sample
    do_reset();
    for (int n = 1; n <= 1021; n++) begin
      xv = ((n - 1) % 5 == 0) ? 16384 : 0;
      xs[n-1] = xv;
      send(16'(xv), 1'b1, 3'd7, out, ok);
      chk("swp_valid", ok, 1);
      chk("swp_lfo_pos", dut.lfo_pos, lfo_model(n));
      if (n <= 513) begin
        expv = xv >>> 1;
      end else begin
        p  = lfo_model(n - 1);
        dl = 256 + (p >>> 4);
        w  = (n - 1) - dl;
        ta = xs[w];
`ifdef CHORUS_INTERP_EN
        tb   = xs[w-1];
        fr   = p % 16;
        wetv = ta + (((tb - ta) * fr) >>> 4);
`else
        wetv = ta;
`endif
        expv = (xv + wetv) >>> 1;
      end
      chk("swp_data", out, expv);
    end

    // Reset during the mix state: outputs clear, no pulse follows
    send(16'sh0555, 1'b0, 3'd0, out, ok);
    chk("pre_rst_data", out, 32'sh0555);
    i_data   = 16'sh0777;
    i_enable = 1'b0;
    i_valid  = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (LAT - 2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_data", o_data, 0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    pulses  = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(posedge i_clk); #1;
      if (o_valid) pulses++;
    end
    chk("midrst_pulses", pulses, 0);
    chk("midrst_o_data_after", o_data, 0);
    chk("midrst_fill_cnt", dut.fill_cnt, 0);

    // A valid during the read state is ignored
    i_data   = 16'sh0111;
    i_enable = 1'b0;
    i_valid  = 1'b1;
    @(posedge i_clk); #1;
    i_data  = 16'sh0222;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    pulses  = 0;
    out     = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      if (o_valid) begin
        pulses++;
        out = o_data;
      end
    end
    chk("busy_pulses", pulses, 1);
    chk("busy_data", out, 32'sh0111);
    chk("busy_wr_ptr", dut.wr_ptr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/effect_chorus.md
# effect_chorus

Modulated-delay chorus stage in the guitar effect chain, placed between the tremolo and the SRAM delay stage. It keeps the recent input history in an on-chip circular buffer. A triangle LFO sweeps a read tap through that history, and the stage outputs the 50/50 mix of the dry sample and the tapped (wet) sample. It uses the same valid-pulse chain protocol as the other effect stages and never touches the external SRAM.

## Interface
- ADDR_W, 10: buffer address width; buffer holds 2^ADDR_W signed 16-bit samples.
- BASE_DLY, 256: minimum tap distance in samples; must be ≥ 2.
- MOD_DEPTH, 255: LFO sweep span in whole samples; BASE_DLY+MOD_DEPTH+2 < 2^ADDR_W.
- i_clk  in  1  audio bit clock (BCLK); single clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  one-cycle pulse marking a new input sample.
- i_enable  in  1  1 = chorus applied, 0 = dry bypass with identical latency.
- i_level  in  3  LFO rate; step = i_level+1 sixteenths of a sample per input sample.
- i_data  in  16  signed input sample.
- o_data  out  16  signed output sample; held between valids.
- o_valid  out  1  one-cycle pulse when o_data is updated.

## Operation
- **Reset values:** o_data=0, o_valid=0, wr_ptr=0, lfo_pos=0, lfo_dir=up, fill_cnt=0, FSM=S_IDLE. Buffer contents are undefined.
- **FSM states:** S_IDLE → S_RD0 → [S_RD1] → S_MIX → S_OUT → S_IDLE.
- **S_IDLE:**
  - On i_valid: latch i_data into dry_r, latch i_enable, write mem[wr_ptr]=i_data.
  - Compute d = BASE_DLY + lfo_pos[int] and addr_a = wr_ptr − d (mod 2^ADDR_W).
  - Increment wr_ptr. Go to S_RD0.
  - i_valid is ignored in every other state. Upstream spacing is ≥64 cycles.
- **S_RD0:** issue synchronous read of addr_a.
- **S_RD1 (interp only):** capture tap_a; issue read of addr_a−1.
- **S_MIX:**
  - Capture the last read (tap_a without interp, tap_b with interp).
  - Form wet (see Configuration).
  - wet is forced to 0 while fill_cnt < BASE_DLY+MOD_DEPTH+2. fill_cnt saturates at that value and increments once per accepted sample.
  - sum = dry_r + wet, 17-bit signed. mix = sum >>> 1 (arithmetic shift, cannot overflow).
- **S_OUT:**
  - o_data = enable ? mix : dry_r; pulse o_valid.
  - Advance the LFO by step = i_level+1 in the current direction.
- **LFO:**
  - lfo_pos is unsigned with 4 fractional bits; range 0 .. MOD_DEPTH·16.
  - On reaching or passing a bound, clamp to the bound and flip lfo_dir.
- **Bypass:** the buffer, fill_cnt and LFO keep running while disabled, so re-enabling has no transient.
- **Read/write spacing:** the read address is always ≥ BASE_DLY behind the write, so there is no read-during-write on the same address.

## Timing
- i_valid sampled at edge T: o_valid is high for exactly one cycle after edge T+4 with CHORUS_INTERP_EN, after edge T+3 without.
- o_data changes only in the cycle o_valid is high.
- i_level and i_enable are sampled only at accept (S_IDLE with i_valid). Mid-sample changes take effect on the next sample.
- Reset asserted mid-operation: outputs return to reset values immediately. No o_valid is issued for the interrupted sample. fill_cnt restarts, so the wet path is muted again until refilled.

## Configuration
- Macro: CHORUS_INTERP_EN.
- **Defined:**
  - frac = lfo_pos[3:0].
  - wet = tap_a + (((tap_b − tap_a) · frac) >>> 4), using a 17-bit difference and a 22-bit signed product.
  - S_RD1 is present; latency is 4.
- **Undefined:**
  - wet = tap_a (the fractional part is truncated).
  - S_RD1 and the multiplier are removed; latency is 3.
  - The LFO still tracks fractional bits so the rate meaning of i_level is unchanged.

## Test plan
- **Bypass latency:** i_enable=0, i_data=0x1234 pulsed → o_data=0x1234 after 4 cycles (3 without macro), o_valid a single-cycle pulse.
- **Fill mute:** after reset, i_enable=1, 600 samples of constant 1000 → first BASE_DLY+MOD_DEPTH+2=513 outputs are 500 (wet muted), thereafter 1000.
- **Extreme mix, no overflow:** buffer filled with 32767, input 32767 → o_data=32767. All −32768 → o_data=−32768.
- **LFO sweep:** i_level=7, impulse train with every 5th sample = 16384 → tap distance sweeps 256..511 and back. The bench checks lfo_pos turning at 0 and 4080 (255·16).
- **Interpolation:** with macro, tap_a=0, tap_b=1600, frac=8 → wet=800, output = (dry+800)>>>1.
- **Reset and busy-window accept:** reset mid-S_MIX → o_valid stays 0, o_data=0. A new i_valid during S_RD0 is ignored and wr_ptr does not advance.
